// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop drive sequencer: excitation codes,
// sequencer states and the target-to-code encoder.
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN
  } state_e;

  // Code that moves a flip-flop holding m to target t; never yields SR_ILLEGAL.
  function automatic logic [1:0] sr_encode(input logic t, input logic m,
                                           input logic prefer_hold);
    logic [1:0] code;
    if (prefer_hold && (t == m)) code = SR_HOLD;
    else                         code = t ? SR_SET : SR_RST;
    return (code == SR_ILLEGAL) ? SR_HOLD : code;
  endfunction

endpackage

// File: rtl/sr_tgt_fifo.sv
// DEPTH-entry 1-bit synchronous FIFO with registered full/empty flags and
// first-word fall-through read data.
module sr_tgt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o,
  output logic empty_d_o
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o    = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign empty_d_o = (count_d == '0);

endmodule

// File: rtl/sr_drive_seq.sv
// Turns a stream of target Q bits into legal SR excitation codes, tracks the
// driven flip-flop's state and checks its fed-back Q two cycles after each pop.
module sr_drive_seq
  import sr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit PREFER_HOLD = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic [1:0]       sr,
  output logic             sr_valid,
  input  logic             q_fb,
  output logic             q_model,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       sr_q, sr_d;
  logic             sr_valid_q, sr_valid_d;
  logic             q_model_q, q_model_d;
  logic             chk_v_q, chk_b_q;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty, fifo_empty_d, fifo_dout, pop;

  sr_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (tgt_valid),
    .din_i     (tgt_bit),
    .pop_i     (pop),
    .dout_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .empty_d_o (fifo_empty_d)
  );

  // DRIVE is entered exactly when the FIFO holds data, so it pops every cycle there.
  assign pop = (state_q == DRIVE) && !fifo_empty;

  always_comb begin
    sr_d       = SR_HOLD;
    sr_valid_d = 1'b0;
    q_model_d  = q_model_q;
    if (pop) begin
      sr_d       = sr_encode(fifo_dout, q_model_q, PREFER_HOLD);
      sr_valid_d = 1'b1;
      q_model_d  = fifo_dout;
    end

    mismatch_d = chk_v_q && (q_fb != chk_b_q);
    cnt_d      = cnt_q;
    if (mismatch_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);

    // Checks outstanding after this edge: the pop now, and the pop one edge ago.
    if (!fifo_empty_d)           state_d = DRIVE;
    else if (pop || sr_valid_q)  state_d = DRAIN;
    else                         state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= SR_HOLD;
      sr_valid_q <= 1'b0;
      q_model_q  <= 1'b0;
      chk_v_q    <= 1'b0;
      chk_b_q    <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sr_valid_q <= sr_valid_d;
      q_model_q  <= q_model_d;
      chk_v_q    <= sr_valid_q;
      chk_b_q    <= q_model_q;
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tgt_ready    = !fifo_full;
  assign sr           = sr_q;
  assign sr_valid     = sr_valid_q;
  assign q_model      = q_model_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sr_drive_seq.sv
// Drives two sequencers (hold-preferring and always-toggle) with one target
// stream and checks them every cycle against a queue-based reference model.
module tb_sr_drive_seq;
  import sr_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tgt_valid = 1'b0, tgt_bit = 1'b0, force0 = 1'b0, inv = 1'b0;

  logic             rdy_w [2];
  logic [1:0]       sr_w  [2];
  logic             sv_w  [2];
  logic             qm_w  [2];
  logic             mm_w  [2];
  logic             busy_w[2];
  logic [CNT_W-1:0] cnt_w [2];
  logic             ff_q  [2];
  logic             q_fb  [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign q_fb[0] = force0 ? 1'b0 : (ff_q[0] ^ inv);
  assign q_fb[1] = force0 ? 1'b0 : (ff_q[1] ^ inv);

  sr_drive_seq #(.DEPTH(DEPTH), .PREFER_HOLD(1'b1), .CNT_W(CNT_W)) u_hold (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy_w[0]), .sr(sr_w[0]), .sr_valid(sv_w[0]), .q_fb(q_fb[0]),
    .q_model(qm_w[0]), .mismatch(mm_w[0]), .mismatch_cnt(cnt_w[0]), .busy(busy_w[0])
  );

  sr_drive_seq #(.DEPTH(DEPTH), .PREFER_HOLD(1'b0), .CNT_W(CNT_W)) u_toggle (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy_w[1]), .sr(sr_w[1]), .sr_valid(sv_w[1]), .q_fb(q_fb[1]),
    .q_model(qm_w[1]), .mismatch(mm_w[1]), .mismatch_cnt(cnt_w[1]), .busy(busy_w[1])
  );

  // Ideal downstream SR flip-flops.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)                    ff_q[i] <= 1'b0;
      else if (sr_w[i] == SR_SET)    ff_q[i] <= 1'b1;
      else if (sr_w[i] == SR_RST)    ff_q[i] <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of accepted targets plus the list of recent pops.
  bit         tq[$];
  bit         p1v = 1'b0, p1b = 1'b0, p2v = 1'b0, p2b = 1'b0;
  bit         push_m, pop_m, t_m;
  logic [1:0] e_sr [2] = '{2'b00, 2'b00};
  bit         e_qm [2] = '{1'b0, 1'b0};
  bit         e_mm [2] = '{1'b0, 1'b0};
  int         e_cnt[2] = '{0, 0};
  bit         e_sv = 1'b0, e_busy = 1'b0, e_ready = 1'b1;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      tq.delete();
      p1v = 1'b0; p2v = 1'b0; e_sv = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
        e_sr[i] = 2'b00; e_qm[i] = 1'b0; e_mm[i] = 1'b0; e_cnt[i] = 0;
      end
    end else begin
      push_m = tgt_valid && e_ready;
      for (int i = 0; i < 2; i++) begin
        e_mm[i] = p2v && (q_fb[i] != p2b);
        if (e_mm[i] && e_cnt[i] < CNT_MAX) e_cnt[i]++;
      end
      p2v   = p1v;
      p2b   = p1b;
      pop_m = (tq.size() > 0);
      t_m   = 1'b0;
      if (pop_m) t_m = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        if (!pop_m)                           e_sr[i] = 2'b00;
        else if (i == 0 && t_m == e_qm[i])    e_sr[i] = 2'b00;
        else                                  e_sr[i] = t_m ? 2'b10 : 2'b01;
        if (pop_m) e_qm[i] = t_m;
      end
      p1v  = pop_m;
      p1b  = t_m;
      e_sv = pop_m;
      if (push_m) tq.push_back(tgt_bit);
      e_busy  = (tq.size() > 0) || p1v || p2v;
      e_ready = (tq.size() < DEPTH);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sr%0d", i),           sr_w[i],   e_sr[i]);
      check($sformatf("sr_valid%0d", i),     sv_w[i],   e_sv);
      check($sformatf("q_model%0d", i),      qm_w[i],   e_qm[i]);
      check($sformatf("mismatch%0d", i),     mm_w[i],   e_mm[i]);
      check($sformatf("mismatch_cnt%0d", i), cnt_w[i], e_cnt[i]);
      check($sformatf("busy%0d", i),         busy_w[i], e_busy);
      check($sformatf("tgt_ready%0d", i),    rdy_w[i],  e_ready);
    end
  end

  logic [1:0] o_sr0[8], o_sr1[8];
  logic       o_sv[8], o_busy[8], o_mm0[8], o_mm1[8];
  logic [1:0] exp_hold[4]   = '{2'b10, 2'b01, 2'b00, 2'b10};
  logic [1:0] exp_toggle[4] = '{2'b10, 2'b01, 2'b01, 2'b10};

  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_sr%0d", i),    sr_w[i],   0);
      check($sformatf("rst_ready%0d", i), rdy_w[i],  1);
      check($sformatf("rst_busy%0d", i),  busy_w[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Stream 1,0,0,1 back-to-back from idle with q_model = 0.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      o_sr0[c] = sr_w[0]; o_sr1[c] = sr_w[1]; o_sv[c] = sv_w[0]; o_busy[c] = busy_w[0];
      case (c)
        0: begin tgt_valid = 1'b1; tgt_bit = 1'b1; end
        1: tgt_bit = 1'b0;
        2: tgt_bit = 1'b0;
        3: tgt_bit = 1'b1;
        4: tgt_valid = 1'b0;
        default: ;
      endcase
    end
    check("seq_sv_before", o_sv[1], 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq_hold_sr%0d", k),   o_sr0[k+2], exp_hold[k]);
      check($sformatf("seq_toggle_sr%0d", k), o_sr1[k+2], exp_toggle[k]);
      check($sformatf("seq_sv%0d", k),        o_sv[k+2],  1);
    end
    check("seq_sv_after",  o_sv[6],   0);
    check("seq_busy_p1",   o_busy[6], 1);
    check("seq_busy_p2",   o_busy[7], 0);
    check("seq_cnt_hold",  cnt_w[0],  0);

    // Target 1 with q_fb held low: mismatch two edges after the pop.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      o_mm0[c] = mm_w[0]; o_mm1[c] = mm_w[1];
      case (c)
        0: begin force0 = 1'b1; tgt_valid = 1'b1; tgt_bit = 1'b1; end
        1: tgt_valid = 1'b0;
        5: force0 = 1'b0;
        default: ;
      endcase
    end
    check("mm_early",    o_mm0[3], 0);
    check("mm_hold",     o_mm0[4], 1);
    check("mm_toggle",   o_mm1[4], 1);
    check("mm_one_shot", o_mm0[5], 0);
    check("mm_cnt_hold",   cnt_w[0], 1);
    check("mm_cnt_toggle", cnt_w[1], 1);

    // Random stream with occasional inverted feedback.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      tgt_valid = ($urandom_range(0, 3) != 0);
      tgt_bit   = 1'($urandom_range(0, 1));
      inv       = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    tgt_valid = 1'b0; inv = 1'b0;
    repeat (5) @(negedge clk);

    // Continuously inverted feedback drives the counter into saturation.
    inv = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_cnt_hold",   cnt_w[0], CNT_MAX);
    check("sat_cnt_toggle", cnt_w[1], CNT_MAX);
    inv = 1'b0;

    // Reset asserted mid-stream, between clock edges.
    @(negedge clk);
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_qm_hold",   qm_w[0], 1);
    check("pre_rst_qm_toggle", qm_w[1], 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_sr%0d", i),   sr_w[i],   0);
      check($sformatf("async_qm%0d", i),   qm_w[i],   0);
      check($sformatf("async_sv%0d", i),   sv_w[i],   0);
      check($sformatf("async_busy%0d", i), busy_w[i], 0);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("post_rst_busy%0d", i),  busy_w[i], 0);
      check($sformatf("post_rst_ready%0d", i), rdy_w[i],  1);
      check($sformatf("post_rst_mm%0d", i),    mm_w[i],   0);
      check($sformatf("post_rst_cnt%0d", i),   cnt_w[i],  0);
    end
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
